// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the PC sequencer.
// Holds the PC width, the default reset vector and the FSM state enum.
package pc_seq_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] DEF_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority selector.
// Ports: i_imem_ready gates every redirect; i_br_* taken branch;
//        i_pend_* captured redirect; i_jump* ID jump; i_hold keeps
//        i_pc; otherwise i_pc_plus4. o_next_pc is the selected PC,
//        o_redirect flags that a redirect target was chosen.
module pc_next_sel
    import pc_seq_pkg::*;
(
    input  logic            i_imem_ready,
    input  logic            i_br_taken,
    input  logic [PC_W-1:0] i_br_target,
    input  logic            i_pend_valid,
    input  logic [PC_W-1:0] i_pend_target,
    input  logic            i_jump,
    input  logic [PC_W-1:0] i_jump_target,
    input  logic            i_hold,
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_pc_plus4,
    output logic [PC_W-1:0] o_next_pc,
    output logic            o_redirect
);

    always_comb begin
        o_next_pc  = i_pc_plus4;
        o_redirect = 1'b0;
        if (i_imem_ready && i_br_taken) begin
            o_next_pc  = i_br_target;
            o_redirect = 1'b1;
        end else if (i_imem_ready && i_pend_valid) begin
            o_next_pc  = i_pend_target;
            o_redirect = 1'b1;
        end else if (i_imem_ready && i_jump) begin
            o_next_pc  = i_jump_target;
            o_redirect = 1'b1;
        end else if (i_hold || !i_imem_ready) begin
            o_next_pc  = i_pc;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register, BOOT/RUN/WAIT FSM, pending redirect.
// Ports: clk, reset (sync, active-high), imem_ready, load_use_stall,
//        jump_id/jump_target_id, branch_ex/zero_ex/branch_target_ex;
//        outputs pc_out, pc_plus4, if_valid, stall_if, flush_ifid,
//        flush_idex, redirect_pending.
// Macro PC_SEQUENCER_DELAY_SLOT_EN: jumps do not flush, taken
//        branches flush IF/ID only (the ID instruction is a delay slot).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            imem_ready,
    input  logic            load_use_stall,
    input  logic            jump_id,
    input  logic [PC_W-1:0] jump_target_id,
    input  logic            branch_ex,
    input  logic            zero_ex,
    input  logic [PC_W-1:0] branch_target_ex,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_plus4,
    output logic            if_valid,
    output logic            stall_if,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            redirect_pending
);

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic            r_pend_valid;
    logic            r_pend_is_br;
    logic [PC_W-1:0] r_pend_target;

    logic            w_active;
    logic            w_taken;
    logic            w_jump;
    logic            w_hold;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_next_pc;
    logic            w_redirect;

    // BOOT and the reset cycle ignore redirects: the pipeline is empty.
    assign w_active   = !reset && (r_state != ST_BOOT);
    assign w_taken    = w_active && branch_ex && zero_ex;
    // A jump beside a taken branch is on the wrong path.
    assign w_jump     = w_active && jump_id && !w_taken;
    assign w_hold     = !w_active || load_use_stall;
    assign w_pc_plus4 = r_pc + 32'd4;

    pc_next_sel u_next_sel (
        .i_imem_ready  (imem_ready),
        .i_br_taken    (w_taken),
        .i_br_target   (branch_target_ex),
        .i_pend_valid  (r_pend_valid),
        .i_pend_target (r_pend_target),
        .i_jump        (w_jump),
        .i_jump_target (jump_target_id),
        .i_hold        (w_hold),
        .i_pc          (r_pc),
        .i_pc_plus4    (w_pc_plus4),
        .o_next_pc     (w_next_pc),
        .o_redirect    (w_redirect)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_next_pc;
        end
    end

    // Redirects seen while memory is busy are parked here. A branch
    // replaces anything; a jump never replaces a parked branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid  <= 1'b0;
            r_pend_is_br  <= 1'b0;
            r_pend_target <= '0;
        end else if (imem_ready) begin
            r_pend_valid  <= 1'b0;
            r_pend_is_br  <= 1'b0;
        end else if (w_taken) begin
            r_pend_valid  <= 1'b1;
            r_pend_is_br  <= 1'b1;
            r_pend_target <= branch_target_ex;
        end else if (w_jump && !(r_pend_valid && r_pend_is_br)) begin
            r_pend_valid  <= 1'b1;
            r_pend_is_br  <= 1'b0;
            r_pend_target <= jump_target_id;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if_valid    = 1'b0;
        stall_if    = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        unique case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  if (!imem_ready) w_state_nxt = ST_WAIT;
            ST_WAIT: if (imem_ready) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase
        if_valid = w_active && (r_state == ST_RUN) && !w_redirect;
        stall_if = w_active && !w_redirect
                   && (load_use_stall || !imem_ready);
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
        flush_ifid = w_taken;
        flush_idex = 1'b0;
`else
        flush_ifid = w_taken || w_jump;
        flush_idex = w_taken;
`endif
    end

    assign pc_out           = r_pc;
    assign pc_plus4         = w_pc_plus4;
    assign redirect_pending = r_pend_valid;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_ready;
    logic        load_use_stall;
    logic        jump_id;
    logic [31:0] jump_target_id;
    logic        branch_ex;
    logic        zero_ex;
    logic [31:0] branch_target_ex;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic        stall_if;
    logic        flush_ifid;
    logic        flush_idex;
    logic        redirect_pending;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PC_SEQUENCER_DELAY_SLOT_EN
    localparam logic J_FL  = 1'b0;
    localparam logic B_FLX = 1'b0;
`else
    localparam logic J_FL  = 1'b1;
    localparam logic B_FLX = 1'b1;
`endif

    pc_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .imem_ready       (imem_ready),
        .load_use_stall   (load_use_stall),
        .jump_id          (jump_id),
        .jump_target_id   (jump_target_id),
        .branch_ex        (branch_ex),
        .zero_ex          (zero_ex),
        .branch_target_ex (branch_target_ex),
        .pc_out           (pc_out),
        .pc_plus4         (pc_plus4),
        .if_valid         (if_valid),
        .stall_if         (stall_if),
        .flush_ifid       (flush_ifid),
        .flush_idex       (flush_idex),
        .redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        imem_ready = 1'b1;
        branch_ex = 1'b1;
        zero_ex = 1'b1;
        branch_target_ex = 32'h40;
        jump_id = 1'b1;
        jump_target_id = 32'h100;
        tick();
        tick();
        reset = 1'b0;
        branch_ex = 1'b0;
        zero_ex = 1'b0;
        jump_id = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h0) begin
            n_err++;
            $display("FAIL rst_pc got=%h exp=%h", pc_out, 32'h0);
        end
        n_cmp++;
        if (if_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ifv got=%b exp=0", if_valid);
        end
        n_cmp++;
        if (stall_if !== 1'b0) begin
            n_err++;
            $display("FAIL rst_stall got=%b exp=0", stall_if);
        end
        n_cmp++;
        if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
            n_err++;
            $display("FAIL rst_flush got=%b%b exp=00",
                     flush_ifid, flush_idex);
        end
        n_cmp++;
        if (redirect_pending !== 1'b0) begin
            n_err++;
            $display("FAIL rst_pend got=%b exp=0", redirect_pending);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h0 || if_valid !== 1'b1) begin
            n_err++;
            $display("FAIL run0 got=%h/%b exp=0/1", pc_out, if_valid);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h4) begin
            n_err++;
            $display("FAIL run4 got=%h exp=%h", pc_out, 32'h4);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h8 || pc_plus4 !== 32'hC) begin
            n_err++;
            $display("FAIL run8 got=%h/%h exp=8/c", pc_out, pc_plus4);
        end
        tick();
    endtask

    // Starts at pc 0xC.
    task automatic test_wrap;
        jump_id = 1'b1;
        jump_target_id = 32'hFFFF_FFFC;
        @(negedge clk);
        n_cmp++;
        if (flush_ifid !== J_FL || flush_idex !== 1'b0
            || if_valid !== 1'b0) begin
            n_err++;
            $display("FAIL jmp_ctl got=%b%b%b exp=%b00",
                     flush_ifid, flush_idex, if_valid, J_FL);
        end
        tick();
        jump_id = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_top got=%h/%h exp=fffffffc/0",
                     pc_out, pc_plus4);
        end
        n_cmp++;
        if (if_valid !== 1'b1 || flush_ifid !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_ctl got=%b%b exp=10", if_valid, flush_ifid);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_zero got=%h exp=0", pc_out);
        end
        tick();
    endtask

    // Starts at pc 0x4.
    task automatic test_branch;
        jump_id = 1'b1;
        jump_target_id = 32'h10;
        tick();
        jump_id = 1'b0;
        branch_ex = 1'b1;
        zero_ex = 1'b1;
        branch_target_ex = 32'h40;
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h10) begin
            n_err++;
            $display("FAIL br_at got=%h exp=10", pc_out);
        end
        n_cmp++;
        if (flush_ifid !== 1'b1 || flush_idex !== B_FLX
            || if_valid !== 1'b0) begin
            n_err++;
            $display("FAIL br_ctl got=%b%b%b exp=1%b0",
                     flush_ifid, flush_idex, if_valid, B_FLX);
        end
        tick();
        branch_ex = 1'b1;
        zero_ex = 1'b0;
        branch_target_ex = 32'h300;
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h40) begin
            n_err++;
            $display("FAIL br_tgt got=%h exp=40", pc_out);
        end
        n_cmp++;
        if (flush_ifid !== 1'b0 || flush_idex !== 1'b0
            || if_valid !== 1'b1) begin
            n_err++;
            $display("FAIL br_nt_ctl got=%b%b%b exp=001",
                     flush_ifid, flush_idex, if_valid);
        end
        tick();
        branch_ex = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h44) begin
            n_err++;
            $display("FAIL br_nt_pc got=%h exp=44", pc_out);
        end
        tick();
    endtask

    // Starts at pc 0x48.
    task automatic test_jump_vs_branch;
        jump_id = 1'b1;
        jump_target_id = 32'h100;
        branch_ex = 1'b1;
        zero_ex = 1'b1;
        branch_target_ex = 32'h80;
        @(negedge clk);
        n_cmp++;
        if (flush_ifid !== 1'b1 || flush_idex !== B_FLX) begin
            n_err++;
            $display("FAIL jb_flush got=%b%b exp=1%b",
                     flush_ifid, flush_idex, B_FLX);
        end
        tick();
        jump_id = 1'b0;
        branch_ex = 1'b0;
        zero_ex = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h80 || redirect_pending !== 1'b0) begin
            n_err++;
            $display("FAIL jb_pc got=%h/%b exp=80/0",
                     pc_out, redirect_pending);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h84) begin
            n_err++;
            $display("FAIL jb_drop got=%h exp=84", pc_out);
        end
        tick();
    endtask

    // Starts at pc 0x88.
    task automatic test_pending_jump;
        int pend_cnt;
        pend_cnt = 0;
        imem_ready = 1'b0;
        jump_id = 1'b1;
        jump_target_id = 32'h200;
        @(negedge clk);
        n_cmp++;
        if (stall_if !== 1'b1 || redirect_pending !== 1'b0
            || flush_ifid !== J_FL) begin
            n_err++;
            $display("FAIL pj_cap got=%b%b%b exp=10%b",
                     stall_if, redirect_pending, flush_ifid, J_FL);
        end
        tick();
        jump_id = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) imem_ready = 1'b1;
            @(negedge clk);
            if (redirect_pending === 1'b1) pend_cnt++;
            n_cmp++;
            if (pc_out !== 32'h88 || if_valid !== 1'b0) begin
                n_err++;
                $display("FAIL pj_hold%0d got=%h/%b exp=88/0",
                         i, pc_out, if_valid);
            end
            tick();
        end
        n_cmp++;
        if (pend_cnt != 3) begin
            n_err++;
            $display("FAIL pj_cnt got=%0d exp=3", pend_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h200 || redirect_pending !== 1'b0
            || if_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pj_load got=%h/%b/%b exp=200/0/1",
                     pc_out, redirect_pending, if_valid);
        end
        tick();
    endtask

    // Starts at pc 0x204.
    task automatic test_pending_prio;
        imem_ready = 1'b0;
        branch_ex = 1'b1;
        zero_ex = 1'b1;
        branch_target_ex = 32'h500;
        tick();
        branch_ex = 1'b0;
        zero_ex = 1'b0;
        jump_id = 1'b1;
        jump_target_id = 32'h600;
        tick();
        jump_id = 1'b0;
        imem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h204 || redirect_pending !== 1'b1) begin
            n_err++;
            $display("FAIL pb_hold got=%h/%b exp=204/1",
                     pc_out, redirect_pending);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h500) begin
            n_err++;
            $display("FAIL pb_keep got=%h exp=500", pc_out);
        end
        tick();
        imem_ready = 1'b0;
        jump_id = 1'b1;
        jump_target_id = 32'h700;
        tick();
        jump_id = 1'b0;
        branch_ex = 1'b1;
        zero_ex = 1'b1;
        branch_target_ex = 32'h720;
        tick();
        branch_ex = 1'b0;
        zero_ex = 1'b0;
        imem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h504) begin
            n_err++;
            $display("FAIL pbo_hold got=%h exp=504", pc_out);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h720) begin
            n_err++;
            $display("FAIL pbo_over got=%h exp=720", pc_out);
        end
        tick();
    endtask

    // Starts at pc 0x724.
    task automatic test_load_use;
        jump_id = 1'b1;
        jump_target_id = 32'h20;
        tick();
        jump_id = 1'b0;
        load_use_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (pc_out !== 32'h20 || stall_if !== 1'b1) begin
                n_err++;
                $display("FAIL lu_hold%0d got=%h/%b exp=20/1",
                         i, pc_out, stall_if);
            end
            tick();
        end
        load_use_stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h20 || stall_if !== 1'b0) begin
            n_err++;
            $display("FAIL lu_rel got=%h/%b exp=20/0", pc_out, stall_if);
        end
        tick();
        load_use_stall = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h24 || stall_if !== 1'b1) begin
            n_err++;
            $display("FAIL lu_s2 got=%h/%b exp=24/1", pc_out, stall_if);
        end
        tick();
        branch_ex = 1'b1;
        zero_ex = 1'b1;
        branch_target_ex = 32'h60;
        @(negedge clk);
        n_cmp++;
        if (stall_if !== 1'b0 || flush_ifid !== 1'b1) begin
            n_err++;
            $display("FAIL lu_br got=%b%b exp=01", stall_if, flush_ifid);
        end
        tick();
        branch_ex = 1'b0;
        zero_ex = 1'b0;
        load_use_stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h60) begin
            n_err++;
            $display("FAIL lu_brpc got=%h exp=60", pc_out);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        imem_ready = 1'b1;
        load_use_stall = 1'b0;
        jump_id = 1'b0;
        jump_target_id = 32'h0;
        branch_ex = 1'b0;
        zero_ex = 1'b0;
        branch_target_ex = 32'h0;
        test_reset();
        test_wrap();
        test_branch();
        test_jump_vs_branch();
        test_pending_jump();
        test_pending_prio();
        test_load_use();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
